// File: rtl/atm_pkg.sv
// Shared definitions for the ATM cash dispenser.
//   atm_state_e : dispenser FSM states
//   ERR_*       : err_code values reported with the error pulse
//   cass_idx_t  : cassette index (0..2); the value 3 marks "past the last cassette"
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_PLAN     = 3'd2,
        ST_FIRE     = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_FINISH   = 3'd5
    } atm_state_e;

    localparam logic [1:0] ERR_ZERO_AMT  = 2'd0;
    localparam logic [1:0] ERR_TOO_LARGE = 2'd1;
    localparam logic [1:0] ERR_NO_CHANGE = 2'd2;
    localparam logic [1:0] ERR_JAM       = 2'd3;

    typedef logic [1:0] cass_idx_t;

    localparam cass_idx_t CASS_END = 2'd3;

endpackage

// File: rtl/atm_note_planner.sv
// Greedy note planner: splits an amount over three cassettes, largest note
// first, never planning more notes than a cassette holds. One action per cycle.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start                : load amount and begin planning (ignored while busy)
//   amount               : amount to split
//   inv0..inv2           : cassette inventories (held stable while busy)
//   busy                 : planning in progress
//   done                 : one-cycle pulse when planning has finished
//   ok                   : valid with done; 1 when the amount was fully covered
//   plan0..plan2         : planned note counts per cassette, valid with done
module atm_note_planner
    import atm_pkg::*;
#(
    parameter int AMT_W  = 32,
    parameter int CNT_W  = 10,
    parameter int DENOM0 = 200,
    parameter int DENOM1 = 100,
    parameter int DENOM2 = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic [CNT_W-1:0] inv0,
    input  logic [CNT_W-1:0] inv1,
    input  logic [CNT_W-1:0] inv2,
    output logic             busy,
    output logic             done,
    output logic             ok,
    output logic [CNT_W-1:0] plan0,
    output logic [CNT_W-1:0] plan1,
    output logic [CNT_W-1:0] plan2
);

    cass_idx_t        k;
    logic [AMT_W-1:0] rem;
    logic [CNT_W-1:0] p [0:2];

    logic [AMT_W-1:0] cur_den;
    logic [CNT_W-1:0] cur_p;
    logic [CNT_W-1:0] cur_inv;
    logic             take;

    // Operands of the cassette under consideration; k == CASS_END selects nothing.
    always_comb begin
        cur_den = '0;
        cur_p   = '0;
        cur_inv = '0;
        case (k)
            2'd0: begin cur_den = AMT_W'(DENOM0); cur_p = p[0]; cur_inv = inv0; end
            2'd1: begin cur_den = AMT_W'(DENOM1); cur_p = p[1]; cur_inv = inv1; end
            2'd2: begin cur_den = AMT_W'(DENOM2); cur_p = p[2]; cur_inv = inv2; end
            default: ;
        endcase
        take = busy && (k != CASS_END) && (rem >= cur_den) && (cur_p < cur_inv);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            k    <= '0;
            rem  <= '0;
            p[0] <= '0;
            p[1] <= '0;
            p[2] <= '0;
        end else if (start && !busy) begin
            busy <= 1'b1;
            k    <= '0;
            rem  <= amount;
            p[0] <= '0;
            p[1] <= '0;
            p[2] <= '0;
        end else if (busy) begin
            if (k == CASS_END) begin
                busy <= 1'b0;
            end else if (take) begin
                p[k] <= p[k] + CNT_W'(1);
                rem  <= rem - cur_den;
            end else begin
                k <= k + 2'd1;
            end
        end
    end

    assign done  = busy && (k == CASS_END);
    assign ok    = (rem == '0);
    assign plan0 = p[0];
    assign plan1 = p[1];
    assign plan2 = p[2];

endmodule

// File: rtl/atm_cash_dispenser.sv
// ATM cash dispenser: accepts an authorised withdrawal, plans notes across three
// cassettes, ejects them one at a time with an ack handshake, and reports
// done or a coded error together with the amount actually paid out.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/ready   : request handshake; a request is taken on a cycle where
//                       both are high, req_amount is sampled on that same edge,
//                       and req_ready never depends on req_valid
//   req_amount        : requested amount
//   refill            : reload all cassettes to INIT_CNT (IDLE only; blocks accept)
//   note_fire/sel     : one-cycle eject command and cassette index
//   note_ack          : mechanism confirms an ejection (only heard in WAIT_ACK)
//   done / error      : one-cycle completion pulses; err_code valid with error
//   disp_total        : amount physically paid out, held until next accept
//   cnt0..cnt2        : cassette inventories
module atm_cash_dispenser
    import atm_pkg::*;
#(
    parameter int AMT_W     = 32,
    parameter int CNT_W     = 10,
    parameter int DENOM0    = 200,
    parameter int DENOM1    = 100,
    parameter int DENOM2    = 50,
    parameter int INIT_CNT  = 100,
    parameter int MAX_NOTES = 40,
    parameter int ACK_TO    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             refill,
    output logic             note_fire,
    output logic [1:0]       note_sel,
    input  logic             note_ack,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [AMT_W-1:0] disp_total,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(MAX_NOTES * DENOM0);
    localparam int               TMR_W   = $clog2(ACK_TO + 1);

    atm_state_e       state;
    logic [AMT_W-1:0] amount;
    logic [CNT_W-1:0] cnt  [0:2];
    logic [CNT_W-1:0] plan [0:2];
    cass_idx_t        cur_k;
    logic [TMR_W-1:0] timer;
    logic             fin_err;

    logic             plan_start, plan_busy, plan_done, plan_ok;
    logic [CNT_W-1:0] plan_p0, plan_p1, plan_p2;
    logic             fire_any;
    cass_idx_t        fire_sel;

    function automatic logic [AMT_W-1:0] denom(input cass_idx_t k);
        logic [AMT_W-1:0] d;
        case (k)
            2'd0:    d = AMT_W'(DENOM0);
            2'd1:    d = AMT_W'(DENOM1);
            default: d = AMT_W'(DENOM2);
        endcase
        return d;
    endfunction

    // The planner starts in the same cycle CHECK decides the amount is plannable.
    assign plan_start = (state == ST_CHECK) && (amount != '0) && (amount <= MAX_AMT) && !plan_busy;

    atm_note_planner #(
        .AMT_W (AMT_W),
        .CNT_W (CNT_W),
        .DENOM0(DENOM0),
        .DENOM1(DENOM1),
        .DENOM2(DENOM2)
    ) u_planner (
        .clk   (clk),
        .reset (reset),
        .start (plan_start),
        .amount(amount),
        .inv0  (cnt[0]),
        .inv1  (cnt[1]),
        .inv2  (cnt[2]),
        .busy  (plan_busy),
        .done  (plan_done),
        .ok    (plan_ok),
        .plan0 (plan_p0),
        .plan1 (plan_p1),
        .plan2 (plan_p2)
    );

    // Lowest cassette index that still has planned notes.
    always_comb begin
        fire_any = 1'b1;
        fire_sel = 2'd0;
        if (plan[0] != '0)      fire_sel = 2'd0;
        else if (plan[1] != '0) fire_sel = 2'd1;
        else if (plan[2] != '0) fire_sel = 2'd2;
        else                    fire_any = 1'b0;
    end

    assign req_ready = (state == ST_IDLE) && !refill;
    assign note_fire = (state == ST_FIRE) && fire_any;
    assign note_sel  = note_fire ? fire_sel : 2'd0;
    assign done      = (state == ST_FINISH) && !fin_err;
    assign error     = (state == ST_FINISH) && fin_err;
    assign cnt0      = cnt[0];
    assign cnt1      = cnt[1];
    assign cnt2      = cnt[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            amount     <= '0;
            disp_total <= '0;
            err_code   <= ERR_ZERO_AMT;
            fin_err    <= 1'b0;
            cur_k      <= '0;
            timer      <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i]  <= CNT_W'(INIT_CNT);
                plan[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (refill) begin
                        for (int i = 0; i < 3; i++) cnt[i] <= CNT_W'(INIT_CNT);
                    end else if (req_valid) begin
                        amount     <= req_amount;
                        disp_total <= '0;
                        for (int i = 0; i < 3; i++) plan[i] <= '0;
                        state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (amount == '0) begin
                        fin_err  <= 1'b1;
                        err_code <= ERR_ZERO_AMT;
                        state    <= ST_FINISH;
                    end else if (amount > MAX_AMT) begin
                        fin_err  <= 1'b1;
                        err_code <= ERR_TOO_LARGE;
                        state    <= ST_FINISH;
                    end else begin
                        state <= ST_PLAN;
                    end
                end
                ST_PLAN: begin
                    if (plan_done) begin
                        if (plan_ok) begin
                            plan[0] <= plan_p0;
                            plan[1] <= plan_p1;
                            plan[2] <= plan_p2;
                            state   <= ST_FIRE;
                        end else begin
                            fin_err  <= 1'b1;
                            err_code <= ERR_NO_CHANGE;
                            state    <= ST_FINISH;
                        end
                    end
                end
                ST_FIRE: begin
                    if (fire_any) begin
                        cur_k <= fire_sel;
                        // timer counts cycles elapsed since the fire pulse
                        timer <= TMR_W'(1);
                        state <= ST_WAIT_ACK;
                    end else begin
                        fin_err <= 1'b0;
                        state   <= ST_FINISH;
                    end
                end
                ST_WAIT_ACK: begin
                    if (note_ack) begin
                        cnt[cur_k]  <= cnt[cur_k] - CNT_W'(1);
                        plan[cur_k] <= plan[cur_k] - CNT_W'(1);
                        disp_total  <= disp_total + denom(cur_k);
                        state       <= ST_FIRE;
                    end else if (timer == TMR_W'(ACK_TO - 1)) begin
                        // error lands ACK_TO cycles after the unanswered fire
                        fin_err  <= 1'b1;
                        err_code <= ERR_JAM;
                        state    <= ST_FINISH;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/atm_cash_dispenser.md
Name: atm_cash_dispenser

Overview:
- Downstream stage of the ATM controller.
- Consumes a withdrawal request (amount) once the controller has authorised it.
- Breaks the amount into notes from three cassettes (greedy, largest first, limited by inventory) and drives the note-eject mechanism one note at a time with an ack handshake.
- Reports completion or a coded error, plus the amount actually paid out, back to the controller.

Parameters:
- AMT_W, 32, width of amounts and totals.
- CNT_W, 10, width of each cassette note counter.
- DENOM0, 200, value of the cassette 0 note (largest).
- DENOM1, 100, value of the cassette 1 note.
- DENOM2, 50, value of the cassette 2 note (smallest).
- INIT_CNT, 100, notes per cassette after reset or refill.
- MAX_NOTES, 40, note limit per request; amounts above MAX_NOTES*DENOM0 are rejected.
- ACK_TO, 16, cycles allowed between note_fire and note_ack before a jam is declared.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  withdrawal request from the ATM controller.
- req_amount  in  AMT_W  amount requested, sampled on accept.
- req_ready  out  1  high when a request can be accepted.
- refill  in  1  restores all cassettes to INIT_CNT (honoured only in IDLE).
- note_fire  out  1  one-cycle pulse commanding one note ejection.
- note_sel  out  2  cassette index for note_fire (0..2).
- note_ack  in  1  mechanism confirms the note was ejected.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on failure.
- err_code  out  2  valid with error: 0 ZERO_AMT, 1 TOO_LARGE, 2 NO_CHANGE, 3 JAM.
- disp_total  out  AMT_W  amount physically dispensed; valid with done/error, held until next accept.
- cnt0, cnt1, cnt2  out  CNT_W each  current cassette inventories.

Behaviour:
- Reset state: IDLE.
  - note_fire, done, error = 0; err_code = 0; disp_total = 0; cnt0..cnt2 = INIT_CNT.
  - Reset mid-operation aborts immediately; no further note_fire is issued.
- States: IDLE, CHECK, PLAN, FIRE, WAIT_ACK, FINISH.
- IDLE:
  - req_ready = !refill.
  - Accept when req_valid && req_ready: latch the amount, clear disp_total and the planned counts, go to CHECK.
  - If refill is high, the counters load INIT_CNT and the request is not accepted that cycle.
  - refill outside IDLE is ignored.
- CHECK (1 cycle), first matching rule wins:
  - amount == 0 → FINISH with ZERO_AMT.
  - amount > MAX_NOTES*DENOM0 → FINISH with TOO_LARGE.
  - otherwise → PLAN with k = 0, rem = amount.
- PLAN (one action per cycle):
  - If rem >= DENOM[k] and planned[k] < cnt[k]: planned[k]++, rem -= DENOM[k].
  - Otherwise k++.
  - When k reaches 3: rem != 0 → FINISH with NO_CHANGE (inventory untouched); rem == 0 → FIRE.
  - Greedy is normative; no backtracking.
- FIRE:
  - Select the lowest index k with planned[k] > 0.
  - Pulse note_fire for 1 cycle with note_sel = k, then go to WAIT_ACK with the timer cleared.
  - If no notes remain → FINISH with success.
- WAIT_ACK:
  - On note_ack: cnt[k]--, planned[k]--, disp_total += DENOM[k], go to FIRE.
  - If ACK_TO cycles elapse without ack → FINISH with JAM; counts reflect acked notes only.
  - note_ack outside WAIT_ACK is ignored.
- FINISH (1 cycle): pulse done or error (with err_code), then go to IDLE.
- Arithmetic:
  - rem and disp_total are unsigned AMT_W.
  - Counters never underflow, because a plan never exceeds inventory.
- Latency: ZERO_AMT and TOO_LARGE errors pulse 2 cycles after accept. Successful path: first note_fire follows PLAN completion by 1 cycle.

Decomposition:
- Shared package atm_pkg holds:
  - the state enum;
  - err_code constants (ERR_ZERO_AMT, ERR_TOO_LARGE, ERR_NO_CHANGE, ERR_JAM);
  - the cassette-index type.
- Denominations remain parameters.
- One natural sub-module, atm_note_planner: it takes amount and inventories and produces planned[0..2] plus an ok/fail result, using the iterative PLAN loop and a start/busy/done handshake.
- The top module holds the FSM, ack timer and inventories.

Test Plan:
1. After reset, request 350, ack 1 cycle after each fire → fires with note_sel 0,1,2 in that order; done pulses; disp_total = 350; cnt0 = cnt1 = cnt2 = 99.
2. Request 0 → error with err_code 0 two cycles after accept; no note_fire; counts stay 100.
3. Request 8001 → TOO_LARGE. Request 8000 → exactly 40 fires on cassette 0; done; cnt0 = 60.
4. Request 75 → NO_CHANGE (plan 50, remainder 25); no fires; counts unchanged.
5. Request 400, ack the first note, withhold the second → error JAM exactly 16 cycles after the second fire; disp_total = 200; cnt0 = 99.
6. Reset asserted during WAIT_ACK of a 300 request → IDLE next cycle, counts = 100, no fire. Then refill and req_valid together in IDLE → req_ready = 0, request not accepted; it is accepted on the following cycle.
